secp256k1_mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one `secp256k1_field_mult` instance among `NUM_REQ` requesters, such as point-add, point-double and inversion engines. It accepts one operand pair at a time over a valid/ready handshake and drives the multiplier's start/done protocol. It returns the reduced product to the granted requester with a one-cycle response pulse, and optionally guards against a hung multiplier with a watchdog.

---
 rtl/secp256k1_mult_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/secp256k1_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : secp256k1_mult_arbiter
// Purpose  : Round-robin arbiter and sequencer sharing one secp256k1 field
//            multiplier among NUM_REQ requesters. One operation is outstanding
//            at a time: IDLE (accept) -> ISSUE (start pulse) -> WAIT (done)
//            -> RESP (one-cycle response pulse) -> IDLE.
// Options  : define SECP_MULT_ARB_WATCHDOG_EN to add a WAIT-state watchdog
//            that aborts a hung multiply with an error response.
// Revision : 1.0 - initial release
// ============================================================================
module secp256k1_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*256-1:0] req_a,
    input  logic [NUM_REQ*256-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [255:0]           rsp_data,
    output logic                   rsp_err,
    output logic                   mul_start,
    output logic [255:0]           mul_a,
    output logic [255:0]           mul_b,
    input  logic [255:0]           mul_result,
    input  logic                   mul_done,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);
    // Requester 0 must win the first arbitration after reset.
    localparam logic [2:0]         LAST_INIT = 3'(NUM_REQ - 1);

    // Parameter legality is checked while elaborating; grant_id is 3 bits
    // and the watchdog counter is 8 bits.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("secp256k1_mult_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state;
    logic [2:0]           last_grant;

    int                   start;
    int                   pos;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [2:0]           sel;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [255:0]         sel_a;
    logic [255:0]         sel_b;
    logic                 timeout_hit;

    // Rotating-priority search: rotate req_valid so bit 0 is last_grant+1,
    // take the lowest set bit, then map the offset back to a requester index.
    always_comb begin
        start = int'(last_grant) + 1;
        if (start >= NUM_REQ) begin
            start = 0;
        end
        rot   = (req_valid >> start) | (req_valid << (NUM_REQ - start));
        found = 1'b0;
        sel   = last_grant;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = start + i;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                sel = 3'(pos);
            end
        end
    end

    // Operand mux for the requester that wins this cycle.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == 3'(i)) begin
                sel_a = req_a[i*256 +: 256];
                sel_b = req_b[i*256 +: 256];
            end
        end
    end

    assign sel_onehot = found ? (ONE_HOT_0 << sel) : '0;

    // The handshake completes in the same IDLE cycle the request is seen, so
    // ready is combinational; it is held low while reset is asserted.
    assign req_ready = (state == S_IDLE && rst_n) ? sel_onehot : '0;

`ifdef SECP_MULT_ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] wd_cnt;
    logic       rsp_err_q;

    // WAIT-cycle counter; cleared during ISSUE so it reads zero on WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // The TIMEOUT-th WAIT cycle without a done pulse triggers the abort.
    assign timeout_hit = (state == S_WAIT) && (wd_cnt == WD_LIMIT);

    // Error flag rides with the abort response only; a coincident done wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= timeout_hit && !mul_done;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // Main sequencer with registered start/response/busy/grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= LAST_INIT;
            grant_id   <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mul_a      <= sel_a;
                        mul_b      <= sel_b;
                        last_grant <= sel;
                        grant_id   <= sel;
                        mul_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_valid <= ONE_HOT_0 << grant_id;
                        state     <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_data  <= '0;
                        rsp_valid <= ONE_HOT_0 << grant_id;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
